// File: rtl/minitb_ahb_pkg.sv
// Shared AHB-lite encodings and slave FSM state type for the miniTB bus models.
package minitb_ahb_pkg;

   localparam logic [1:0] HtransIdle   = 2'b00;
   localparam logic [1:0] HtransBusy   = 2'b01;
   localparam logic [1:0] HtransNonseq = 2'b10;
   localparam logic [1:0] HtransSeq    = 2'b11;

   localparam logic [1:0] HrespOkay    = 2'b00;
   localparam logic [1:0] HrespError   = 2'b01;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StLast,
      StErr1,
      StErr2
   } slave_state_t;

endpackage

// File: rtl/minitb_ahb_slave_if.sv
// AHB-lite single-slave bus bundle; the master drives control and write data.
interface minitb_ahb_slave_if #(
   parameter int unsigned AddrWidth = 8,
   parameter int unsigned DataWidth = 32
) ();

   logic                 hsel;
   logic [1:0]           htrans;
   logic [AddrWidth-1:0] haddr;
   logic                 hwrite;
   logic [DataWidth-1:0] hwdata;
   logic                 hready;
   logic [1:0]           hresp;
   logic [DataWidth-1:0] hrdata;

   modport master (
      output hsel, htrans, haddr, hwrite, hwdata,
      input  hready, hresp, hrdata
   );

   modport slave (
      input  hsel, htrans, haddr, hwrite, hwdata,
      output hready, hresp, hrdata
   );

endinterface

// File: rtl/minitb_ahb_slave_ram.sv
// Word RAM with one synchronous write port and one registered read port; no reset.
module minitb_ahb_slave_ram #(
   parameter int unsigned AddrWidth = 8,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Depth     = 256
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] waddr_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic                 re_i,
   input  logic [AddrWidth-1:0] raddr_i,
   output logic [DataWidth-1:0] rdata_o
);

   localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

   logic [DataWidth-1:0] mem [Depth];

   // Callers only present in-range addresses, so the upper bits are dropped.
   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i[IdxWidth-1:0]] <= wdata_i;
      if (re_i) rdata_o <= mem[raddr_i[IdxWidth-1:0]];
   end

endmodule

// File: rtl/minitb_ahb_slave.sv
// AHB-lite responder: word RAM with programmable wait states and a two-cycle
// ERROR response for addresses at or beyond Depth.
module minitb_ahb_slave
   import minitb_ahb_pkg::*;
#(
   parameter int unsigned AddrWidth  = 8,
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned Depth      = 2 ** AddrWidth,
   parameter int unsigned WaitStates = 0
) (
   input logic               hclk,
   input logic               hresetn,
   minitb_ahb_slave_if.slave bus
);

   localparam logic [AddrWidth:0] DepthLim = Depth[AddrWidth:0];

   slave_state_t         state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [AddrWidth-1:0] addr_q;
   logic                 write_q;
   logic                 err_q;
   logic                 from_ram_q;
   logic [DataWidth-1:0] fwd_q;

   logic                 accept;
   logic                 addr_err;
   logic                 ram_we;
   logic                 ram_re;
   logic                 fwd_hit;
   logic [AddrWidth-1:0] rd_addr;
   logic                 rd_write;
   logic [DataWidth-1:0] ram_rdata;

   assign bus.hready = !(state_q == StWait || state_q == StErr1);
   assign bus.hresp  = (state_q == StErr1 || state_q == StErr2) ? HrespError : HrespOkay;
   assign bus.hrdata = from_ram_q ? ram_rdata : fwd_q;

   assign accept   = bus.hready && bus.hsel &&
                     (bus.htrans == HtransNonseq || bus.htrans == HtransSeq);
   assign addr_err = {1'b0, bus.haddr} >= DepthLim;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle, StLast, StErr2: begin
            if (!accept) begin
               state_d = StIdle;
            end else if (addr_err) begin
               state_d = StErr1;
            end else if (WaitStates == 0) begin
               state_d = StLast;
            end else begin
               state_d = StWait;
               cnt_d   = 4'(WaitStates);
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = StLast;
         end
         StErr1:  state_d = StErr2;
         default: state_d = StIdle;
      endcase
   end

   // The read that enters LAST uses the live address phase unless it was parked in WAIT.
   always_comb begin
      ram_we   = (state_q == StLast) && write_q && !err_q;
      rd_addr  = (state_q == StWait) ? addr_q : bus.haddr;
      rd_write = (state_q == StWait) ? write_q : bus.hwrite;
      ram_re   = (state_d == StLast) && !rd_write;
      fwd_hit  = ram_we && (addr_q == rd_addr);
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         write_q    <= 1'b0;
         err_q      <= 1'b0;
         from_ram_q <= 1'b0;
         fwd_q      <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= bus.haddr;
            write_q <= bus.hwrite;
            err_q   <= addr_err;
         end
         if (ram_re) begin
            from_ram_q <= !fwd_hit;
            if (fwd_hit) fwd_q <= bus.hwdata;
         end
      end
   end

   minitb_ahb_slave_ram #(
      .AddrWidth (AddrWidth),
      .DataWidth (DataWidth),
      .Depth     (Depth)
   ) u_ram (
      .clk_i   (hclk),
      .we_i    (ram_we),
      .waddr_i (addr_q),
      .wdata_i (bus.hwdata),
      .re_i    (ram_re),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata)
   );

endmodule

// File: tb/tb_minitb_ahb_slave.sv
// Directed bench for minitb_ahb_slave: three instances (0 waits, 2 waits, depth 128)
// share one master driver; hsel is steered to the instance under test.
module tb_minitb_ahb_slave;
   import minitb_ahb_pkg::*;

   logic        hclk = 1'b0;
   logic        hresetn = 1'b0;
   logic [1:0]  tgt = 2'd0;
   logic        hsel = 1'b0;
   logic [1:0]  htrans = 2'b00;
   logic [7:0]  haddr = 8'h00;
   logic        hwrite = 1'b0;
   logic [31:0] hwdata = 32'h0;
   logic        hready_m;
   logic [1:0]  hresp_m;
   logic [31:0] hrdata_m;
   int          checks = 0;
   int          failures = 0;

   always #5 hclk = ~hclk;

   minitb_ahb_slave_if #(.AddrWidth(8), .DataWidth(32)) b0 ();
   minitb_ahb_slave_if #(.AddrWidth(8), .DataWidth(32)) b2 ();
   minitb_ahb_slave_if #(.AddrWidth(8), .DataWidth(32)) bd ();

   assign b0.hsel = hsel && (tgt == 2'd0);
   assign b2.hsel = hsel && (tgt == 2'd1);
   assign bd.hsel = hsel && (tgt == 2'd2);
   assign b0.htrans = htrans;
   assign b2.htrans = htrans;
   assign bd.htrans = htrans;
   assign b0.haddr = haddr;
   assign b2.haddr = haddr;
   assign bd.haddr = haddr;
   assign b0.hwrite = hwrite;
   assign b2.hwrite = hwrite;
   assign bd.hwrite = hwrite;
   assign b0.hwdata = hwdata;
   assign b2.hwdata = hwdata;
   assign bd.hwdata = hwdata;

   minitb_ahb_slave #(.AddrWidth(8), .DataWidth(32), .Depth(256), .WaitStates(0)) u0 (
      .hclk(hclk), .hresetn(hresetn), .bus(b0));
   minitb_ahb_slave #(.AddrWidth(8), .DataWidth(32), .Depth(256), .WaitStates(2)) u2 (
      .hclk(hclk), .hresetn(hresetn), .bus(b2));
   minitb_ahb_slave #(.AddrWidth(8), .DataWidth(32), .Depth(128), .WaitStates(0)) ud (
      .hclk(hclk), .hresetn(hresetn), .bus(bd));

   always_comb begin
      hready_m = b0.hready;
      hresp_m  = b0.hresp;
      hrdata_m = b0.hrdata;
      case (tgt)
         2'd1: begin hready_m = b2.hready; hresp_m = b2.hresp; hrdata_m = b2.hrdata; end
         2'd2: begin hready_m = bd.hready; hresp_m = bd.hresp; hrdata_m = bd.hrdata; end
         default: ;
      endcase
   end

   // One complete transfer from a negedge; waits=-1 if hready never returned.
   task automatic xfer(input logic [1:0] t, input logic wr, input logic [7:0] a,
                       input logic [31:0] wd, output int waits, output logic [31:0] rd,
                       output logic [1:0] resp);
      tgt = t; hsel = 1'b1; htrans = HtransNonseq; haddr = a; hwrite = wr;
      @(negedge hclk);
      hwdata = wd;
      waits = 0;
      while (hready_m !== 1'b1 && waits < 20) begin
         waits++;
         @(negedge hclk);
      end
      if (hready_m !== 1'b1) waits = -1;
      rd = hrdata_m;
      resp = hresp_m;
      hsel = 1'b0; htrans = HtransIdle;
      @(negedge hclk);
   endtask

   task automatic test_reset();
      hresetn = 1'b0;
      repeat (2) @(negedge hclk);
      checks++; if (b0.hready !== 1'b1 || b2.hready !== 1'b1 || bd.hready !== 1'b1) begin
         failures++; $display("FAIL reset_hready: got %b%b%b want 111", b0.hready, b2.hready, bd.hready); end
      checks++; if (b0.hresp !== 2'b00 || b2.hresp !== 2'b00 || bd.hresp !== 2'b00) begin
         failures++; $display("FAIL reset_hresp: got %b %b %b want 00", b0.hresp, b2.hresp, bd.hresp); end
      checks++; if (b0.hrdata !== 32'h0 || b2.hrdata !== 32'h0 || bd.hrdata !== 32'h0) begin
         failures++; $display("FAIL reset_hrdata: got %h %h %h want 0", b0.hrdata, b2.hrdata, bd.hrdata); end
      checks++; if (u0.state_q !== StIdle || u0.cnt_q !== 4'd0) begin
         failures++; $display("FAIL reset_state: got %0d/%0d want 0/0", u0.state_q, u0.cnt_q); end
      hresetn = 1'b1;
      @(negedge hclk);
   endtask

   task automatic test_ws0_write_read();
      int w; logic [31:0] rd; logic [1:0] rs;
      xfer(2'd0, 1'b1, 8'h10, 32'hDEADBEEF, w, rd, rs);
      checks++; if (w !== 0 || rs !== HrespOkay) begin
         failures++; $display("FAIL ws0_write: got waits=%0d resp=%b want 0/00", w, rs); end
      xfer(2'd0, 1'b0, 8'h10, 32'h0, w, rd, rs);
      checks++; if (w !== 0) begin
         failures++; $display("FAIL ws0_read_waits: got %0d want 0", w); end
      checks++; if (rd !== 32'hDEADBEEF) begin
         failures++; $display("FAIL ws0_read_data: got %h want deadbeef", rd); end
   endtask

   task automatic test_wait_states();
      int w; logic [31:0] rd; logic [1:0] rs;
      xfer(2'd1, 1'b1, 8'h05, 32'h12345678, w, rd, rs);
      checks++; if (w !== 2) begin
         failures++; $display("FAIL ws2_write_waits: got %0d want 2", w); end
      checks++; if (u2.u_ram.mem[5] !== 32'h12345678) begin
         failures++; $display("FAIL ws2_ram_commit: got %h want 12345678", u2.u_ram.mem[5]); end
      xfer(2'd1, 1'b0, 8'h05, 32'h0, w, rd, rs);
      checks++; if (w !== 2 || rd !== 32'h12345678) begin
         failures++; $display("FAIL ws2_read: got waits=%0d data=%h want 2/12345678", w, rd); end
   endtask

   task automatic test_back_to_back();
      int w; logic [31:0] rd; logic [1:0] rs;
      xfer(2'd0, 1'b1, 8'h20, 32'h11111111, w, rd, rs);
      tgt = 2'd0; hsel = 1'b1; htrans = HtransNonseq; haddr = 8'h20; hwrite = 1'b1;
      @(negedge hclk);
      checks++; if (hready_m !== 1'b1) begin
         failures++; $display("FAIL b2b_write_last: got hready=%b want 1", hready_m); end
      hwdata = 32'hA5A5A5A5; hwrite = 1'b0;
      @(negedge hclk);
      checks++; if (hready_m !== 1'b1 || hrdata_m !== 32'hA5A5A5A5) begin
         failures++; $display("FAIL b2b_forward: got hready=%b data=%h want 1/a5a5a5a5",
                              hready_m, hrdata_m); end
      hsel = 1'b0; htrans = HtransIdle;
      @(negedge hclk);
      xfer(2'd0, 1'b0, 8'h20, 32'h0, w, rd, rs);
      checks++; if (rd !== 32'hA5A5A5A5) begin
         failures++; $display("FAIL b2b_reread: got %h want a5a5a5a5", rd); end
   endtask

   task automatic test_error();
      int w; logic [31:0] rd; logic [1:0] rs;
      xfer(2'd2, 1'b1, 8'h10, 32'hCAFEF00D, w, rd, rs);
      xfer(2'd2, 1'b1, 8'h7F, 32'h7F7F7F7F, w, rd, rs);
      xfer(2'd2, 1'b0, 8'h10, 32'h0, w, rd, rs);
      checks++; if (rd !== 32'hCAFEF00D) begin
         failures++; $display("FAIL err_setup_read: got %h want cafef00d", rd); end
      tgt = 2'd2; hsel = 1'b1; htrans = HtransNonseq; haddr = 8'h80; hwrite = 1'b0;
      @(negedge hclk);
      checks++; if (hready_m !== 1'b0 || hresp_m !== HrespError || hrdata_m !== 32'hCAFEF00D) begin
         failures++; $display("FAIL err1: got hready=%b hresp=%b data=%h want 0/01/cafef00d",
                              hready_m, hresp_m, hrdata_m); end
      hsel = 1'b0; htrans = HtransIdle;
      @(negedge hclk);
      checks++; if (hready_m !== 1'b1 || hresp_m !== HrespError || hrdata_m !== 32'hCAFEF00D) begin
         failures++; $display("FAIL err2: got hready=%b hresp=%b data=%h want 1/01/cafef00d",
                              hready_m, hresp_m, hrdata_m); end
      @(negedge hclk);
      checks++; if (hready_m !== 1'b1 || hresp_m !== HrespOkay) begin
         failures++; $display("FAIL err_done: got hready=%b hresp=%b want 1/00", hready_m, hresp_m); end
      xfer(2'd2, 1'b1, 8'h90, 32'h00000001, w, rd, rs);
      checks++; if (w !== 1 || rs !== HrespError) begin
         failures++; $display("FAIL err_write: got waits=%0d resp=%b want 1/01", w, rs); end
      xfer(2'd2, 1'b0, 8'h10, 32'h0, w, rd, rs);
      checks++; if (rd !== 32'hCAFEF00D) begin
         failures++; $display("FAIL err_no_alias_write: got %h want cafef00d", rd); end
      xfer(2'd2, 1'b0, 8'h7F, 32'h0, w, rd, rs);
      checks++; if (w !== 0 || rs !== HrespOkay || rd !== 32'h7F7F7F7F) begin
         failures++; $display("FAIL err_last_word: got waits=%0d resp=%b data=%h want 0/00/7f7f7f7f",
                              w, rs, rd); end
   endtask

   task automatic test_no_accept();
      int w; logic [31:0] rd; logic [1:0] rs;
      tgt = 2'd0; hsel = 1'b1; htrans = HtransBusy; haddr = 8'h10; hwrite = 1'b1; hwdata = 32'h0;
      for (int i = 0; i < 2; i++) begin
         @(negedge hclk);
         checks++; if (hready_m !== 1'b1 || u0.state_q !== StIdle) begin
            failures++; $display("FAIL busy_ignored: got hready=%b state=%0d want 1/0",
                                 hready_m, u0.state_q); end
      end
      hsel = 1'b0; htrans = HtransNonseq;
      for (int i = 0; i < 2; i++) begin
         @(negedge hclk);
         checks++; if (hready_m !== 1'b1 || u0.state_q !== StIdle) begin
            failures++; $display("FAIL hsel0_ignored: got hready=%b state=%0d want 1/0",
                                 hready_m, u0.state_q); end
      end
      htrans = HtransIdle;
      xfer(2'd0, 1'b0, 8'h10, 32'h0, w, rd, rs);
      checks++; if (rd !== 32'hDEADBEEF) begin
         failures++; $display("FAIL no_accept_ram: got %h want deadbeef", rd); end
   endtask

   task automatic test_reset_mid();
      int w; logic [31:0] rd; logic [1:0] rs;
      xfer(2'd1, 1'b1, 8'h03, 32'h0BADF00D, w, rd, rs);
      xfer(2'd1, 1'b0, 8'h03, 32'h0, w, rd, rs);
      checks++; if (rd !== 32'h0BADF00D) begin
         failures++; $display("FAIL rst_setup_read: got %h want 0badf00d", rd); end
      tgt = 2'd1; hsel = 1'b1; htrans = HtransNonseq; haddr = 8'h03; hwrite = 1'b1;
      @(negedge hclk);
      checks++; if (hready_m !== 1'b0) begin
         failures++; $display("FAIL rst_in_wait: got hready=%b want 0", hready_m); end
      hwdata = 32'hFFFFFFFF;
      hresetn = 1'b0;
      #1;
      checks++; if (hready_m !== 1'b1 || hresp_m !== HrespOkay || hrdata_m !== 32'h0) begin
         failures++; $display("FAIL rst_immediate: got hready=%b hresp=%b data=%h want 1/00/0",
                              hready_m, hresp_m, hrdata_m); end
      hsel = 1'b0; htrans = HtransIdle;
      repeat (2) @(negedge hclk);
      hresetn = 1'b1;
      @(negedge hclk);
      xfer(2'd1, 1'b0, 8'h03, 32'h0, w, rd, rs);
      checks++; if (w !== 2 || rd !== 32'h0BADF00D) begin
         failures++; $display("FAIL rst_no_commit: got waits=%0d data=%h want 2/0badf00d", w, rd); end
   endtask

   initial begin
      test_reset();
      test_ws0_write_read();
      test_wait_states();
      test_back_to_back();
      test_error();
      test_no_accept();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

endmodule
